// File: rtl/sumador_pkg.sv
// Shared types and constants for the serial adder/subtractor controller.
//   state_e  : controller FSM state (IDLE/RUN/DONE, 2-bit encoding)
//   SLICE_W  : number of operand bits consumed per cycle by the adder slice
package sumador_pkg;

  localparam int unsigned SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/Sumador_1.sv
// 2-bit ripple adder slice: {C_out, S} = A + B + C_in (purely combinational).
//   A, B   in  2  slice operands
//   C_in   in  1  carry into the slice
//   S      out 2  slice sum
//   C_out  out 1  carry out of the slice
module Sumador_1
  import sumador_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               C_in,
  output logic [SLICE_W-1:0] S,
  output logic               C_out
);

  localparam int unsigned SUM_W = SLICE_W + 1;

  logic [SUM_W-1:0] sum_c;

  assign sum_c = SUM_W'(A) + SUM_W'(B) + SUM_W'(C_in);
  assign S     = sum_c[SLICE_W-1:0];
  assign C_out = sum_c[SLICE_W];

endmodule

// File: rtl/sumador_serie_ctrl.sv
// Multi-cycle WIDTH-bit adder/subtractor: operands are latched on a start
// handshake and fed LSB-first, SLICE_W bits per cycle, through one Sumador_1
// slice with a registered carry. Result appears after WIDTH/SLICE_W cycles.
// Optional feature macro: SUMADOR_OVF_EN adds the signed-overflow output ovf.
//   clk, rst     clock / async active-high reset
//   start        request, accepted only while idle
//   sub          0: A+B+C_in, 1: A-B-C_in (as A+~B+~C_in)
//   A, B, C_in   operands, sampled on the accepting edge
//   busy         high from accept until the done cycle ends
//   done         one-cycle pulse, S/C_out valid
//   S, C_out     result and final carry, held until next completion
//   ovf          signed overflow (SUMADOR_OVF_EN only)
module sumador_serie_ctrl
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
`ifdef SUMADOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N     = WIDTH / SLICE_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               co_q, co_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SUMADOR_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic               sl_co;

  // Current slice of the latched operands, selected by the slice counter.
  assign sl_a = SLICE_W'(a_q >> (cnt_q * SLICE_W));
  assign sl_b = SLICE_W'(b_q >> (cnt_q * SLICE_W));

  Sumador_1 u_slice (
    .A     (sl_a),
    .B     (sl_b),
    .C_in  (c_q),
    .S     (sl_s),
    .C_out (sl_co)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef SUMADOR_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction folds into addition: invert B and the carry-in once.
          a_d     = A;
          b_d     = B ^ {WIDTH{sub}};
          c_d     = C_in ^ sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Slice sums enter at the top so the LSB slice ends at bit 0.
        res_d = {sl_s, res_q[WIDTH-1:SLICE_W]};
        c_d   = sl_co;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          s_d     = res_d;
          co_d    = sl_co;
`ifdef SUMADOR_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[SLICE_W-1] != a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUMADOR_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      s_q     <= s_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUMADOR_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign C_out = co_q;
`ifdef SUMADOR_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Directed self-checking bench for sumador_serie_ctrl (WIDTH=8).
module tb_sumador_serie_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C_out;
`ifdef SUMADOR_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] last_s = '0;
  logic             last_c = 1'b0;

  sumador_serie_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .C_out (C_out)
`ifdef SUMADOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, check handshake timing, result and hold behaviour.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic sb,
                       input logic [7:0] exp_s, input logic exp_c, input logic exp_ovf);
    int edges;
    bit seen;
    @(negedge clk);
    A = a; B = b; C_in = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;                       // E0
    check({tag, ".busy_e0"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b; C_in = ~ci; sub = ~sb;
    edges = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 2) check({tag, ".s_held"}, 32'(S), 32'(last_s));
      if (done) seen = 1;
    end
    check({tag, ".latency"}, 32'(edges), 32'd4);
    check({tag, ".S"}, 32'(S), 32'(exp_s));
    check({tag, ".C_out"}, 32'(C_out), 32'(exp_c));
`ifdef SUMADOR_OVF_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    last_s = exp_s;
    last_c = exp_c;
    @(posedge clk); #1;                       // E5
    check({tag, ".busy_e5"}, {busy, done}, 32'd0);
    check({tag, ".S_hold"}, 32'(S), 32'(exp_s));
  endtask

  initial begin
    int pulses;
    int first_edge;
    rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0; C_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.outs", {busy, done, C_out}, 32'd0);
    check("reset.S", 32'(S), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("add_5a_33",   8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b0);
    do_op("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("add_ff_cin",  8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("sub_10_01",   8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
    do_op("sub_00_01",   8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    do_op("sub_10_01_b", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);
    do_op("add_7f_01",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("add_01_01",   8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    do_op("sub_80_01",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // start pulse at E2 with new operands must be ignored.
    @(negedge clk);
    A = 8'h12; B = 8'h34; C_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // E0
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;                       // E1
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; C_in = 1'b1; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;                       // E2
    @(negedge clk); start = 1'b0;
    pulses = 0; first_edge = 0;
    for (int e = 3; e <= 10; e++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first_edge == 0) first_edge = e;
        check("ignore.S", 32'(S), 32'h46);
        check("ignore.C_out", 32'(C_out), 32'd0);
      end
    end
    check("ignore.pulses", 32'(pulses), 32'd1);
    check("ignore.edge", 32'(first_edge), 32'd4);
    last_s = 8'h46;

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    A = 8'hFF; B = 8'h01; C_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // E0
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid.S", 32'(S), 32'd0);
    check("rst_mid.flags", {busy, done, C_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_s = '0;
    do_op("after_rst", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
